// File: rtl/hub_rx_deframer_pkg.sv
// Shared constants and types for the HUB serial receive path.
package hub_rx_deframer_pkg;
  localparam int         HUB_BYTE_W = 8;
  localparam logic [7:0] HUB_SFD    = 8'hAB;
  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_DATA    = 1'b1;

  typedef struct packed {
    logic                  last;
    logic [HUB_BYTE_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/hub_byte_fifo.sv
// Synchronous {last, data} byte FIFO; a write into a full FIFO is accepted only alongside a pop.
module hub_byte_fifo
  import hub_rx_deframer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  rx_entry_t wr_data,
  output logic      full,
  input  logic      rd_en,
  output rx_entry_t rd_data,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            rd_ok, wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/hub_rx_deframer.sv
// Per-port serial receiver: hunts the SFD, deserializes LSB-first bytes, queues them for the HUB.
module hub_rx_deframer
  import hub_rx_deframer_pkg::*;
#(
  parameter int FRAME_BYTES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [HUB_BYTE_W-1:0] rx_data,
  output logic                  rx_last,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overflow
);
  logic [0:0] state;
  // Only the seven most recent bits need storing; the eighth is the live rx sample.
  logic [6:0] window;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;

  logic [7:0] sampled, new_byte;
  logic       byte_done, is_last, full, empty;
  rx_entry_t  head;

  assign sampled   = {window, rx};
  assign new_byte  = {rx, shift};
  assign byte_done = (state == ST_DATA) && (bit_cnt == 3'd7);
  assign is_last   = (byte_cnt == 4'(FRAME_BYTES-1));

  assign rx_valid = !empty;
  assign rx_data  = head.data;
  assign rx_last  = head.last;
  assign busy     = (state == ST_DATA);

  hub_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (byte_done),
    .wr_data ('{last: is_last, data: new_byte}),
    .full    (full),
    .rd_en   (rx_ready),
    .rd_data (head),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_HUNT;
      window   <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= byte_done && full && !(rx_ready && !empty);
      if (state == ST_HUNT) begin
        window <= sampled[6:0];
        if (sampled == HUB_SFD) begin
          state    <= ST_DATA;
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
      end else begin
        shift   <= {rx, shift[6:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          // Clearing the window forces a fresh 8-bit SFD after every frame.
          if (is_last) begin
            state  <= ST_HUNT;
            window <= '0;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
      end
    end
  end
endmodule
